// File: rtl/writeback_pc_block.sv
// Write-back and PC-update stage of the SEQ Y86-64 core: 15-entry register file, next-PC select, sticky status.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_pc_block #(
    parameter logic [63:0] STACK_INIT = 64'd4095
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               commit,
    input  logic [3:0]         Ins_Code,
    input  logic [3:0]         Ins_fun,
    input  logic [3:0]         rA,
    input  logic [3:0]         rB,
    input  logic               Cnd,
    input  logic signed [63:0] Value_E,
    input  logic signed [63:0] Value_M,
    input  logic [63:0]        Val_P,
    input  logic [63:0]        Val_C,
    input  logic               PC_mem_invalid_check,
    input  logic               instruction_invalid_check,
    input  logic               imemory_error,
    input  logic [3:0]         srcA,
    input  logic [3:0]         srcB,
    output logic [63:0]        valA,
    output logic [63:0]        valB,
    output logic [63:0]        PC,
    output logic [1:0]         status,
    output logic               halted,
    output logic [63:0]        retired_count
);

    typedef enum logic [1:0] {
        S_AOK = 2'd0,
        S_HLT = 2'd1,
        S_ADR = 2'd2,
        S_INS = 2'd3
    } state_t;

    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [3:0] R_RSP  = 4'd4;

    state_t      state_q;
    state_t      state_next;
    logic [63:0] regs [0:14];
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] pc_next;
    logic        retire;

    // ifun is already folded into Cnd upstream; it has no role here.
    logic unused_ins_fun;
    assign unused_ins_fun = ^Ins_fun;

    assign valA   = (srcA == R_NONE) ? 64'd0 : regs[srcA];
    assign valB   = (srcB == R_NONE) ? 64'd0 : regs[srcB];
    assign status = state_q;
    assign halted = (state_q != S_AOK);

    always_comb begin
        dst_e      = R_NONE;
        dst_m      = R_NONE;
        pc_next    = Val_P;
        state_next = state_q;

        case (Ins_Code)
            4'h2:                      dst_e = Cnd ? rB : R_NONE;
            4'h3, 4'h6:                dst_e = rB;
            4'h8, 4'h9, 4'hA, 4'hB:    dst_e = R_RSP;
            default:                   dst_e = R_NONE;
        endcase

        if (Ins_Code == 4'h5 || Ins_Code == 4'hB)
            dst_m = rA;

        case (Ins_Code)
            4'h7:    pc_next = Cnd ? Val_C : Val_P;
            4'h8:    pc_next = Val_C;
            4'h9:    pc_next = Value_M;
            default: pc_next = Val_P;
        endcase

        if (commit && state_q == S_AOK) begin
            if (PC_mem_invalid_check || imemory_error)
                state_next = S_ADR;
            else if (instruction_invalid_check)
                state_next = S_INS;
            else if (Ins_Code == 4'h0)
                state_next = S_HLT;
        end

        // Only instructions that stay in AOK have architectural effect.
        retire = commit && (state_q == S_AOK) && (state_next == S_AOK);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_AOK;
            PC      <= 64'd0;
        end else begin
            state_q <= state_next;
            if (retire)
                PC <= pc_next;
        end
    end

    // M write is issued last so it overrides E when both target one register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= (i == 4) ? STACK_INIT : 64'd0;
        end else if (retire) begin
            if (dst_e != R_NONE)
                regs[dst_e] <= Value_E;
            if (dst_m != R_NONE)
                regs[dst_m] <= Value_M;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset_n)
            count_q <= 64'd0;
        else if (retire)
            count_q <= count_q + 64'd1;
    end

    assign retired_count = count_q;
`else
    assign retired_count = 64'd0;
`endif

endmodule

// File: tb/tb_writeback_pc_block.sv
// Directed self-checking bench for writeback_pc_block; expected values are hand-computed.
module tb_writeback_pc_block;

    logic               clk;
    logic               reset_n;
    logic               commit;
    logic [3:0]         Ins_Code;
    logic [3:0]         Ins_fun;
    logic [3:0]         rA;
    logic [3:0]         rB;
    logic               Cnd;
    logic signed [63:0] Value_E;
    logic signed [63:0] Value_M;
    logic [63:0]        Val_P;
    logic [63:0]        Val_C;
    logic               PC_mem_invalid_check;
    logic               instruction_invalid_check;
    logic               imemory_error;
    logic [3:0]         srcA;
    logic [3:0]         srcB;
    logic [63:0]        valA;
    logic [63:0]        valB;
    logic [63:0]        PC;
    logic [1:0]         status;
    logic               halted;
    logic [63:0]        retired_count;

    int          checks;
    int          errors;
    int          n_ret;
    logic [63:0] rv;

    writeback_pc_block #(.STACK_INIT(64'd4095)) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .commit                    (commit),
        .Ins_Code                  (Ins_Code),
        .Ins_fun                   (Ins_fun),
        .rA                        (rA),
        .rB                        (rB),
        .Cnd                       (Cnd),
        .Value_E                   (Value_E),
        .Value_M                   (Value_M),
        .Val_P                     (Val_P),
        .Val_C                     (Val_C),
        .PC_mem_invalid_check      (PC_mem_invalid_check),
        .instruction_invalid_check (instruction_invalid_check),
        .imemory_error             (imemory_error),
        .srcA                      (srcA),
        .srcB                      (srcB),
        .valA                      (valA),
        .valB                      (valB),
        .PC                        (PC),
        .status                    (status),
        .halted                    (halted),
        .retired_count             (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [3:0] r, output logic [63:0] v);
        srcA = r;
        #1;
        v = valA;
    endtask

    task automatic set_ins(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                           input logic cnd, input logic [63:0] ve, input logic [63:0] vm,
                           input logic [63:0] vp, input logic [63:0] vc,
                           input logic adr, input logic ins, input logic mem);
        Ins_Code = ic;
        rA = ra;
        rB = rb;
        Cnd = cnd;
        Value_E = ve;
        Value_M = vm;
        Val_P = vp;
        Val_C = vc;
        PC_mem_invalid_check = adr;
        instruction_invalid_check = ins;
        imemory_error = mem;
    endtask

    task automatic fire();
        commit = 1'b1;
        @(posedge clk);
        #1;
        commit = 1'b0;
        PC_mem_invalid_check = 1'b0;
        instruction_invalid_check = 1'b0;
        imemory_error = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        n_ret = 0;
    endtask

    function automatic logic [63:0] exp_cnt(input int n);
`ifdef WB_RETIRE_COUNT_EN
        return 64'(n);
`else
        return 64'd0 + 64'(n - n);
`endif
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        n_ret = 0;
        commit = 1'b0;
        Ins_fun = 4'd0;
        srcA = 4'hF;
        srcB = 4'hF;
        set_ins(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        chk("rst_pc", PC, 64'd0);
        chk("rst_status", {62'd0, status}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_count", retired_count, 64'd0);
        for (int r = 0; r < 15; r++) begin
            rd(4'(r), rv);
            chk($sformatf("rst_r%0d", r), rv, (r == 4) ? 64'd4095 : 64'd0);
        end
        srcA = 4'hF;
        srcB = 4'hF;
        #1;
        chk("rd15_a", valA, 64'd0);
        chk("rd15_b", valB, 64'd0);

        // irmovq $0x55,%rdx; old value visible during the commit cycle
        set_ins(4'h3, 4'hF, 4'd2, 1'b0, 64'h55, 64'd0, 64'd10, 64'h55, 1'b0, 1'b0, 1'b0);
        srcB = 4'd2;
        #1;
        chk("nobypass_r2", valB, 64'd0);
        fire();
        n_ret++;
        chk("irmov_r2", valB, 64'h55);
        chk("irmov_pc", PC, 64'd10);
        chk("irmov_cnt", retired_count, exp_cnt(n_ret));

        // popq %rsp: M write wins over E write to R4
        set_ins(4'hB, 4'd4, 4'hF, 1'b0, 64'd4096, 64'h1234, 64'd12, 64'd0, 1'b0, 1'b0, 1'b0);
        fire();
        n_ret++;
        rd(4'd4, rv);
        chk("popq_rsp", rv, 64'h1234);
        chk("popq_pc", PC, 64'd12);

        // cmov not taken, then taken
        set_ins(4'h2, 4'd2, 4'd3, 1'b0, 64'h55, 64'd0, 64'd14, 64'd0, 1'b0, 1'b0, 1'b0);
        fire();
        n_ret++;
        rd(4'd3, rv);
        chk("cmov_nt_r3", rv, 64'd0);
        chk("cmov_nt_pc", PC, 64'd14);
        set_ins(4'h2, 4'd2, 4'd3, 1'b1, 64'h77, 64'd0, 64'd16, 64'd0, 1'b0, 1'b0, 1'b0);
        fire();
        n_ret++;
        rd(4'd3, rv);
        chk("cmov_t_r3", rv, 64'h77);
        chk("cmov_t_pc", PC, 64'd16);

        // jXX not taken, then taken
        set_ins(4'h7, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 64'd25, 64'h40, 1'b0, 1'b0, 1'b0);
        fire();
        n_ret++;
        chk("jxx_nt_pc", PC, 64'd25);
        set_ins(4'h7, 4'hF, 4'hF, 1'b1, 64'd0, 64'd0, 64'd34, 64'h40, 1'b0, 1'b0, 1'b0);
        fire();
        n_ret++;
        chk("jxx_t_pc", PC, 64'h40);

        // call: PC <- Val_C, rsp <- Value_E
        set_ins(4'h8, 4'hF, 4'hF, 1'b0, 64'h1228, 64'd0, 64'h49, 64'h100, 1'b0, 1'b0, 1'b0);
        fire();
        n_ret++;
        chk("call_pc", PC, 64'h100);
        rd(4'd4, rv);
        chk("call_rsp", rv, 64'h1228);
        chk("call_cnt", retired_count, exp_cnt(n_ret));

        // No commit: nothing moves
        set_ins(4'h3, 4'hF, 4'd7, 1'b0, 64'd9, 64'd0, 64'h200, 64'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("idle_pc", PC, 64'h100);
        rd(4'd7, rv);
        chk("idle_r7", rv, 64'd0);

        // mrmovq with data-address error
        set_ins(4'h5, 4'd5, 4'hF, 1'b0, 64'd0, 64'h99, 64'h10A, 64'd0, 1'b0, 1'b0, 1'b1);
        fire();
        chk("adr_status", {62'd0, status}, 64'd2);
        chk("adr_halted", {63'd0, halted}, 64'd1);
        chk("adr_pc", PC, 64'h100);
        rd(4'd5, rv);
        chk("adr_r5", rv, 64'd0);
        chk("adr_cnt", retired_count, exp_cnt(n_ret));

        // Later valid commit ignored
        set_ins(4'h3, 4'hF, 4'd6, 1'b0, 64'h66, 64'd0, 64'h10A, 64'd0, 1'b0, 1'b0, 1'b0);
        fire();
        rd(4'd6, rv);
        chk("absorb_r6", rv, 64'd0);
        chk("absorb_pc", PC, 64'h100);
        chk("absorb_status", {62'd0, status}, 64'd2);

        // Reset from error state
        do_reset();
        chk("rerst_status", {62'd0, status}, 64'd0);
        chk("rerst_pc", PC, 64'd0);
        chk("rerst_cnt", retired_count, 64'd0);
        rd(4'd2, rv);
        chk("rerst_r2", rv, 64'd0);
        rd(4'd4, rv);
        chk("rerst_rsp", rv, 64'd4095);

        // ret then halt
        set_ins(4'h9, 4'hF, 4'hF, 1'b0, 64'h1000, 64'h20, 64'd1, 64'd0, 1'b0, 1'b0, 1'b0);
        fire();
        n_ret++;
        chk("ret_pc", PC, 64'h20);
        rd(4'd4, rv);
        chk("ret_rsp", rv, 64'h1000);
        set_ins(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 64'h21, 64'd0, 1'b0, 1'b0, 1'b0);
        fire();
        chk("hlt_status", {62'd0, status}, 64'd1);
        chk("hlt_halted", {63'd0, halted}, 64'd1);
        chk("hlt_pc", PC, 64'h20);
        chk("hlt_cnt", retired_count, exp_cnt(n_ret));

        // ADR outranks INS
        do_reset();
        set_ins(4'h3, 4'hF, 4'd1, 1'b0, 64'h11, 64'd0, 64'd10, 64'd0, 1'b1, 1'b1, 1'b0);
        fire();
        chk("prio_status", {62'd0, status}, 64'd2);
        rd(4'd1, rv);
        chk("prio_r1", rv, 64'd0);

        // Illegal instruction
        do_reset();
        set_ins(4'h3, 4'hF, 4'd1, 1'b0, 64'h11, 64'd0, 64'd10, 64'd0, 1'b0, 1'b1, 1'b0);
        fire();
        chk("ins_status", {62'd0, status}, 64'd3);
        chk("ins_pc", PC, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_pc_block.md
# writeback_pc_block

Write-back and PC-update stage of the SEQ Y86-64 processor, directly downstream of `MemoryBlock`. It consumes the execute result (`Value_E`), the memory result (`Value_M`) and the memory error flags. On each commit it writes the register file, selects the next PC and advances the sticky processor status. It also owns the 15-entry register file, whose two combinational read ports serve decode.

## Interface
- `STACK_INIT`, default 4095: reset value of `%rsp` (R4); the top of the 4096-word data memory.
- `clk`  in  1  : sole clock; all state changes on its rising edge.
- `reset_n`  in  1  : synchronous, active-low reset.
- `commit`  in  1  : one-cycle strobe; the current instruction retires at this edge.
- `Ins_Code`, `Ins_fun`  in  4 each  : icode and ifun of the retiring instruction.
- `rA`, `rB`  in  4 each  : register specifiers; 15 means no register.
- `Cnd`  in  1  : condition result from execute.
- `Value_E`, `Value_M`  in  64 each (signed)  : ALU result and memory read data.
- `Val_P`, `Val_C`  in  64 each  : fall-through PC and the constant/destination word.
- `PC_mem_invalid_check`, `instruction_invalid_check`, `imemory_error`  in  1 each  : fetch-address, illegal-instruction and data-address error flags. `x` is treated as 0.
- `srcA`, `srcB`  in  4 each  : decode read addresses.
- `valA`, `valB`  out  64 each  : combinational read data; 0 when the address is 15.
- `PC`  out  64  : current PC.
- `status`  out  2  : 0 = AOK, 1 = HLT, 2 = ADR, 3 = INS.
- `halted`  out  1  : high whenever `status` is not AOK.
- `retired_count`  out  64  : count of retired instructions (see Configuration).

## Operation
- Destination E, `dstE`:
  - icode 2 (cmov): `rB` if `Cnd` is 1, else 15.
  - icode 3 and 6: `rB`.
  - icode 8, 9, 10 and 11: 4.
  - All other icodes: 15.
- Destination M, `dstM`:
  - icode 5 and 11: `rA`.
  - All other icodes: 15.
- Register writes: `R[dstE] <= Value_E` and `R[dstM] <= Value_M`. A write to register 15 is discarded.
- If `dstE == dstM` (for example `popq %rsp`), the M write wins.
- Next PC:
  - icode 8: `Val_C`.
  - icode 7 with `Cnd` = 1: `Val_C`.
  - icode 9: `Value_M`.
  - Otherwise: `Val_P`.
- Status FSM, evaluated on commit while in AOK. Conditions are checked in this priority order:
  - `PC_mem_invalid_check` or `imemory_error` → ADR.
  - `instruction_invalid_check` → INS.
  - icode 0 → HLT.
  - Otherwise the state stays AOK.
- An instruction that leaves AOK makes no register write and no PC change, so `PC` stays on the faulting or halt instruction.
- HLT, ADR and INS are absorbing. Every later commit is ignored until reset.
- `commit` = 0: no state changes.

## Timing
- Register writes, PC, status and counter all update at the rising edge where `commit` = 1. Results are visible the cycle after.
- Reads are combinational and have no bypass. A read in the same cycle as a commit to the same register returns the old value.
- Reset, on a rising edge with `reset_n` = 0:
  - `PC` = 0, `status` = AOK, `halted` = 0, `retired_count` = 0.
  - R4 = `STACK_INIT`; all other registers = 0.
- Reset takes priority over a simultaneous `commit`. Resetting in the middle of a program, or from a halted or error state, fully re-initialises the block.
- All arithmetic is 64-bit and wraps. `retired_count` wraps from 2^64−1 to 0.

## Configuration
- `WB_RETIRE_COUNT_EN` defined:
  - `retired_count` increments by 1 on each commit that stays in AOK.
  - Halt and faulting instructions are not counted.
- Not defined: `retired_count` is tied to 0 and no counter flop exists.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold `reset_n` = 0 for 2 cycles → `PC` = 0, `status` = 0, R4 reads 4095, R0..R3 and R5..R14 read 0, reads of 15 return 0.
- irmovq: `Ins_Code` = 3, `rB` = 2, `Value_E` = 0x55, `Val_P` = 10, commit → R2 = 0x55, `PC` = 10. Counter = 1 when `WB_RETIRE_COUNT_EN` is defined, 0 when it is not.
- popq %rsp: `Ins_Code` = 11, `rA` = 4, `Value_E` = 4096, `Value_M` = 0x1234, commit → R4 = 0x1234 (M wins).
- cmov and jXX:
  - cmov with `Cnd` = 0, `rB` = 3 → R3 unchanged, `PC` = `Val_P`.
  - jXX with `Cnd` = 1, `Val_C` = 0x40 → `PC` = 0x40.
- Data-address error: mrmovq with `rA` = 5 and `imemory_error` = 1 → `status` = 2, `halted` = 1, R5 and `PC` unchanged. A following valid irmovq commit is ignored. Reset restores AOK.
- ret then halt:
  - ret with `Value_M` = 0x20 → `PC` = 0x20, R4 = `Value_E`.
  - Then halt (`Ins_Code` = 0) → `status` = 1, `PC` stays 0x20.
